uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one byte-wide UART transmit serializer between N packet requesters. Each requester offers a packet of 1..MAX_LEN bytes over a valid/ready byte stream. The arbiter grants one requester at a time in round-robin order and locks that grant until the packet ends. When HEADER_EN=1 it prefixes each packet with a channel-ID byte. It sits between the debug/telemetry sources and the TX serializer, whose ready is high only while the serializer is idle.

## Interface
Parameters:
- N, 4: number of requesters, 2..8.
- MAX_LEN, 64: maximum payload bytes per grant, 1..255.
- HEADER_EN, 1: 1 = emit a header byte before each packet.
- HEADER_BASE, 8'hA0: header byte = HEADER_BASE | channel index; the low 3 bits of HEADER_BASE must be 0.

Ports:
- CLK, input, 1: single clock; all logic is on the rising edge.
- RESET_N, input, 1: synchronous, active-low reset, sampled on the rising edge of CLK.
- in_data, input, N*8: requester i byte is in_data[8i+7:8i].
- in_valid, input, N: requester i has a byte available.
- in_last, input, N: requester i's current byte is the final byte of its packet.
- in_ready, output, N: requester i's byte is consumed at this edge when in_valid[i] is also high.
- tx_data, output, 8: byte to the serializer (registered).
- tx_valid, output, 1: tx_data holds a byte (registered).
- tx_ready, input, 1: serializer accepts tx_data at this edge when tx_valid is high.
- grant, output, N: one-hot owner of the channel; all zeros when no requester holds it (registered).
- busy, output, 1: high when state != IDLE or tx_valid is high.

## Operation
- Output register: holds one byte. A byte is transferred out when tx_valid && tx_ready at an edge. "out_free" means !tx_valid || tx_ready.
- State IDLE:
  - When out_free and any in_valid bit is set, pick the first set bit scanning last_grant+1, last_grant+2, … mod N.
  - Set grant to that requester, last_grant <= index, cnt <= 0.
  - HEADER_EN=1: load tx_data <= HEADER_BASE | index, tx_valid <= 1.
  - Go to PAYLOAD.
  - The grant is committed even if the chosen in_valid drops next cycle.
- State PAYLOAD:
  - in_ready[g] = out_free for the granted index g; in_ready is 0 for all other bits and in every other state.
  - On a transfer (in_valid[g] && in_ready[g]): tx_data <= byte, tx_valid <= 1, cnt <= cnt+1.
  - If in_last[g] is set or cnt == MAX_LEN-1 (forced end): grant <= 0 and go to IDLE. A requester truncated by the forced end re-arbitrates for its remaining bytes as a new packet.
  - If the requester stalls (in_valid low), the grant stays held indefinitely. There is no timeout.
- Output register with no new byte loaded: if tx_valid && tx_ready then tx_valid <= 0; otherwise tx_data and tx_valid hold.
- in_last on a non-granted requester has no effect.
- cnt is 8 bits wide and never exceeds MAX_LEN-1.
- Reset (RESET_N=0 at an edge) takes priority over everything. It sets:
  - state = IDLE, tx_valid = 0, tx_data = 0, grant = 0, cnt = 0.
  - last_grant = N-1, so requester 0 has first priority.
  - A packet in flight at reset is abandoned, including any byte held in tx_data. Requesters must restart it.

## Timing
- in_ready and busy are combinational. All other outputs are registered.
- IDLE with in_valid seen at edge k: grant and header are visible after edge k. The earliest payload byte is accepted at edge k+1, when tx_ready is high or the header has already gone.
- HEADER_EN=0: the earliest payload byte is accepted at edge k+1, since the output register is free.
- A payload byte accepted at edge k appears on tx_data/tx_valid after edge k.
- Back-to-back packets: after the last byte is accepted at edge k, IDLE can grant at edge k+1 once out_free.
- Peak throughput is one byte per cycle when tx_ready is held high. The practical rate is set by the serializer.
- tx_valid never deasserts and tx_data never changes while a byte is unaccepted.

## Test plan
- Single packet: reset, then requester 2 sends 3 bytes 11,22,33 with last on 33, tx_ready always 1 → tx bytes A2,11,22,33; grant = 0100 through the last transfer, then 0000.
- Round-robin: requesters 0 and 3 each hold a 1-byte packet valid continuously → headers alternate A0, A3, A0, A3; never two consecutive grants to the same requester while the other is waiting.
- Backpressure: tx_ready high for 1 cycle every 100 cycles → tx_data stable while tx_valid is high; no byte lost or duplicated; in_ready low while the output register is full.
- MAX_LEN=4, requester 1 streams 6 bytes with no last until byte 6 → A1,b1..b4 then A1,b5,b6, with re-arbitration between the two.
- HEADER_EN=0, requester 0 stalls mid-packet for 50 cycles while requester 1 is valid → requester 1 gets no in_ready until requester 0 sends last; no header bytes are emitted.
- RESET_N low mid-packet with tx_valid high → next cycle tx_valid=0, grant=0; after release, requester 0 wins arbitration when all requesters are valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART TX serializer between N packet requesters.
// A grant is locked until packet end; an optional channel-ID header precedes each packet.
module uart_tx_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned MAX_LEN     = 64,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [N*8-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StPayload} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic          out_free;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          found;
    logic [IW-1:0] pick;

    assign out_free = !tx_valid_q || tx_ready;
    assign g_valid  = |(in_valid & grant_q);
    assign g_last   = |(in_last & grant_q);

    always_comb begin
        g_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            g_data = g_data | (in_data[i*8 +: 8] & {8{grant_q[i]}});
        end
    end

    // Requesters above last_q win first; otherwise wrap around starting from index 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (IW'(i) > last_q)) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                found = 1'b1;
                pick  = IW'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            last_q     <= IW'(N - 1);
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !tx_ready;
        unique case (state_q)
            StIdle: begin
                if (out_free && found) begin
                    state_d = StPayload;
                    grant_d = N'(1) << pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    if (HEADER_EN) begin
                        tx_data_d  = HEADER_BASE | 8'(pick);
                        tx_valid_d = 1'b1;
                    end
                end
            end
            StPayload: begin
                if (g_valid && out_free) begin
                    tx_data_d  = g_data;
                    tx_valid_d = 1'b1;
                    // A forced end at MAX_LEN leaves the rest of the packet to re-arbitrate.
                    if (g_last || (cnt_q == 8'(MAX_LEN - 1))) begin
                        state_d = StIdle;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if ((state_q == StPayload) && out_free) begin
            in_ready = grant_q;
        end
        busy = (state_q != StIdle) || tx_valid_q;
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a headered MAX_LEN=4 instance plus a headerless instance,
// checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int ML = 4;

    logic         CLK;
    logic         RESET_N;
    logic [31:0]  in_data;
    logic [3:0]   in_valid, in_last, in_ready, grant;
    logic [7:0]   tx_data;
    logic         tx_valid, tx_ready, busy;

    logic [31:0]  b_in_data;
    logic [3:0]   b_in_valid, b_in_last, b_in_ready, b_grant;
    logic [7:0]   b_tx_data;
    logic         b_tx_valid, b_tx_ready, b_busy;

    int tests = 0;
    int fails = 0;

    // Requester packet storage: {last, data} per byte, consumed through rd pointers.
    logic [8:0] mem [N][64];
    int         wr [N];
    int         rd [N];
    logic [7:0] exp_q [$];
    logic [7:0] obs [$];
    int         viol_stab, viol_rdy;
    logic [3:0] grant_or;
    bit         timed_out;

    uart_tx_arbiter #(.N(4), .MAX_LEN(ML), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.N(4), .MAX_LEN(64), .HEADER_EN(1'b0), .HEADER_BASE(8'hA0)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_last(b_in_last), .in_ready(b_in_ready), .tx_data(b_tx_data),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .grant(b_grant), .busy(b_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; tx_ready = 1'b1;
        b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_tx_ready = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
    endtask

    task automatic add_packet(input int r, input int len, input logic [7:0] first, input bit rnd);
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = rnd ? 8'($urandom) : first + 8'(k * 17);
            mem[r][wr[r]] = {(k == len - 1), d};
            wr[r]++;
        end
    endtask

    // Packet-level model: round-robin over requesters with pending bytes, header then
    // up to ML bytes or until the last flag.
    task automatic build_expected();
        int         p [N];
        int         last, idx, cnt;
        bit         any;
        logic [8:0] e;
        exp_q.delete();
        for (int i = 0; i < N; i++) p[i] = rd[i];
        last = N - 1;
        while (1) begin
            any = 0;
            idx = 0;
            for (int k = 1; k <= N; k++) begin
                if (!any && p[(last + k) % N] < wr[(last + k) % N]) begin
                    any = 1;
                    idx = (last + k) % N;
                end
            end
            if (!any) break;
            last = idx;
            exp_q.push_back(8'hA0 | 8'(idx));
            cnt = 0;
            do begin
                e = mem[idx][p[idx]];
                p[idx]++;
                cnt++;
                exp_q.push_back(e[7:0]);
            end while (!e[8] && cnt < ML && p[idx] < wr[idx]);
        end
    endtask

    // Drives the stored packets into the headered DUT and records what leaves it.
    // mode 0: tx_ready always 1, 1: random, 2: one cycle in every 100.
    task automatic run_stream(input int mode, input int budget);
        int         cyc;
        bit         prev_hold;
        logic [7:0] prev_data;
        obs.delete();
        viol_stab = 0; viol_rdy = 0; grant_or = '0; prev_hold = 0; prev_data = '0;
        cyc = 0;
        while (obs.size() < exp_q.size() && cyc < budget) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (rd[i] < wr[i]) begin
                    in_valid[i]      = 1'b1;
                    in_data[i*8 +: 8] = mem[i][rd[i]][7:0];
                    in_last[i]       = mem[i][rd[i]][8];
                end else begin
                    in_valid[i]      = 1'b0;
                    in_data[i*8 +: 8] = 8'h00;
                    in_last[i]       = 1'b0;
                end
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = ((cyc % 100) == 99);
            endcase
            #1;
            grant_or = grant_or | grant;
            if (prev_hold && (!tx_valid || tx_data !== prev_data)) viol_stab++;
            if (tx_valid && !tx_ready && in_ready !== 4'b0000) viol_rdy++;
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) obs.push_back(tx_data);
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && in_ready[i]) rd[i]++;
            end
            cyc++;
        end
        timed_out = (obs.size() < exp_q.size());
        @(negedge CLK);
        in_valid = '0; in_last = '0; tx_ready = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (tx_valid !== 1'b0 || grant !== 4'b0000 || tx_data !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: tx_valid=%b grant=%b tx_data=%h busy=%b, want 0 0000 00 0",
                     tx_valid, grant, tx_data, busy);
        end
        tests++;
        if (in_ready !== 4'b0000 || b_in_ready !== 4'b0000 || b_tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b b_in_ready=%b b_tx_valid=%b, want 0000 0000 0",
                     in_ready, b_in_ready, b_tx_valid);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] lit [4] = '{8'hA2, 8'h11, 8'h22, 8'h33};
        do_reset();
        clear_mem();
        add_packet(2, 3, 8'h11, 0);
        build_expected();
        run_stream(0, 200);
        tests++;
        if (timed_out || obs.size() != 4) begin
            fails++;
            $display("FAIL single_count: got %0d bytes, want 4", obs.size());
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== lit[i]) begin
                fails++;
                $display("FAIL single_byte%0d: got %h, want %h", i, obs[i], lit[i]);
            end
        end
        tests++;
        if (grant_or !== 4'b0100 || grant !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: seen=%b final=%b busy=%b, want 0100 0000 0",
                     grant_or, grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] lit [12] = '{8'hA0, 8'h01, 8'hA3, 8'h31, 8'hA0, 8'h01,
                                 8'hA3, 8'h31, 8'hA0, 8'h01, 8'hA3, 8'h31};
        do_reset();
        clear_mem();
        for (int p = 0; p < 3; p++) begin
            add_packet(0, 1, 8'h01, 0);
            add_packet(3, 1, 8'h31, 0);
        end
        build_expected();
        run_stream(0, 300);
        tests++;
        if (timed_out || obs.size() != 12) begin
            fails++;
            $display("FAIL rr_count: got %0d bytes, want 12", obs.size());
        end
        for (int i = 0; i < 12 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== lit[i]) begin
                fails++;
                $display("FAIL rr_byte%0d: got %h, want %h", i, obs[i], lit[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_mem();
        add_packet(1, 3, 8'h40, 1);
        add_packet(2, 2, 8'h50, 1);
        build_expected();
        run_stream(2, 1500);
        tests++;
        if (timed_out || obs.size() != exp_q.size()) begin
            fails++;
            $display("FAIL bp_count: got %0d bytes, want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL bp_byte%0d: got %h, want %h", i, obs[i], exp_q[i]);
            end
        end
        tests++;
        if (viol_stab != 0 || viol_rdy != 0) begin
            fails++;
            $display("FAIL bp_protocol: unstable=%0d ready_while_full=%0d, want 0 0",
                     viol_stab, viol_rdy);
        end
    endtask

    task automatic test_truncation();
        logic [7:0] lit [8] = '{8'hA1, 8'h10, 8'h21, 8'h32, 8'h43, 8'hA1, 8'h54, 8'h65};
        do_reset();
        clear_mem();
        add_packet(1, 6, 8'h10, 0);
        build_expected();
        run_stream(1, 500);
        tests++;
        if (timed_out || obs.size() != 8) begin
            fails++;
            $display("FAIL trunc_count: got %0d bytes, want 8", obs.size());
        end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            tests++;
            if (obs[i] !== lit[i]) begin
                fails++;
                $display("FAIL trunc_byte%0d: got %h, want %h", i, obs[i], lit[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            do_reset();
            clear_mem();
            for (int r = 0; r < N; r++) begin
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    add_packet(r, $urandom_range(1, 6), 8'h00, 1);
                end
            end
            build_expected();
            run_stream(1, 3000);
            tests++;
            if (timed_out || obs.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d bytes, want %0d", it, obs.size(),
                         exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                tests++;
                if (obs[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand%0d_byte%0d: got %h, want %h", it, i, obs[i], exp_q[i]);
                end
            end
            tests++;
            if (viol_stab != 0 || viol_rdy != 0) begin
                fails++;
                $display("FAIL rand%0d_protocol: unstable=%0d ready_while_full=%0d, want 0 0",
                         it, viol_stab, viol_rdy);
            end
        end
    endtask

    task automatic test_stall_no_header();
        logic [7:0] bobs [$];
        logic [7:0] lit [3] = '{8'h5A, 8'h5B, 8'h77};
        int         r0_sent, stall, leak, bad_grant;
        bit         r1_sent;
        do_reset();
        r0_sent = 0; stall = 0; leak = 0; bad_grant = 0; r1_sent = 0;
        for (int c = 0; c < 200 && !r1_sent; c++) begin
            @(negedge CLK);
            b_tx_ready = 1'b1;
            b_in_data  = {16'h0000, 8'h77, (r0_sent == 0) ? 8'h5A : 8'h5B};
            if (r0_sent == 0) begin
                b_in_valid[0] = 1'b1; b_in_last[0] = 1'b0;
            end else if (r0_sent == 1 && stall < 50) begin
                b_in_valid[0] = 1'b0; b_in_last[0] = 1'b0;
                stall++;
            end else if (r0_sent == 1) begin
                b_in_valid[0] = 1'b1; b_in_last[0] = 1'b1;
            end else begin
                b_in_valid[0] = 1'b0; b_in_last[0] = 1'b0;
            end
            b_in_valid[1] = 1'b1;
            b_in_last[1]  = 1'b1;
            #1;
            if (r0_sent < 2 && b_in_ready[1]) leak++;
            if (r0_sent == 1 && b_grant !== 4'b0001) bad_grant++;
            if (b_tx_valid && b_tx_ready) bobs.push_back(b_tx_data);
            if (b_in_valid[0] && b_in_ready[0]) r0_sent++;
            if (b_in_valid[1] && b_in_ready[1]) r1_sent = 1;
        end
        @(negedge CLK);
        b_in_valid = '0; b_in_last = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (b_tx_valid && b_tx_ready) bobs.push_back(b_tx_data);
            @(negedge CLK);
        end
        tests++;
        if (leak != 0 || bad_grant != 0 || stall != 50) begin
            fails++;
            $display("FAIL stall_hold: leaked_ready=%0d bad_grant=%0d stall=%0d, want 0 0 50",
                     leak, bad_grant, stall);
        end
        tests++;
        if (bobs.size() != 3) begin
            fails++;
            $display("FAIL stall_count: got %0d bytes, want 3", bobs.size());
        end
        for (int i = 0; i < 3 && i < bobs.size(); i++) begin
            tests++;
            if (bobs[i] !== lit[i]) begin
                fails++;
                $display("FAIL stall_byte%0d: got %h, want %h", i, bobs[i], lit[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        in_valid = 4'b0001; in_last = 4'b0000; in_data = 32'h0000_0055; tx_ready = 1'b0;
        @(negedge CLK);
        #1;
        tests++;
        if (tx_valid !== 1'b1 || grant !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_pre: tx_valid=%b grant=%b, want 1 0001", tx_valid, grant);
        end
        RESET_N = 1'b0;
        @(negedge CLK);
        #1;
        tests++;
        if (tx_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_clear: tx_valid=%b grant=%b busy=%b, want 0 0000 0",
                     tx_valid, grant, busy);
        end
        RESET_N = 1'b1;
        in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'h4433_2211; tx_ready = 1'b1;
        @(negedge CLK);
        #1;
        tests++;
        if (grant !== 4'b0001 || tx_data !== 8'hA0 || tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_rearb: grant=%b tx_data=%h tx_valid=%b, want 0001 a0 1",
                     grant, tx_data, tx_valid);
        end
        do_reset();
    endtask

    initial begin
        RESET_N = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; tx_ready = 1'b1;
        b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_tx_ready = 1'b1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_random();
        test_stall_no_header();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
